// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a WIDTH-cycle shift-add multiplier that
// stalls ID/EX while it runs; all EX/MEM outputs are registered.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | single-cycle ops pass straight through; a multiply is latched here
// MUL   | shift-add iteration; bubbles to EX/MEM until the last iteration
module ex_stage #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             IRegWrite,
   input  logic             IMemWrite,
   input  logic             IMemRead,
   input  logic             IRegStore,
   input  logic             IBranch,
   input  logic             IALUSrc,
   input  logic [2:0]       IALUOP,
   input  logic [WIDTH-1:0] IRs1Val,
   input  logic [WIDTH-1:0] IRs2Val,
   input  logic [WIDTH-1:0] IImm,
   input  logic [WIDTH-1:0] IDest,
   output logic             ORegWrite,
   output logic             OMemWrite,
   output logic             OMemRead,
   output logic             ORegStore,
   output logic             OBranchTaken,
   output logic [WIDTH-1:0] OResult,
   output logic [WIDTH-1:0] OStoreData,
   output logic [WIDTH-1:0] ODest,
   output logic             Stall
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;

   logic             reg_write_q, reg_write_d;
   logic             mem_write_q, mem_write_d;
   logic             mem_read_q, mem_read_d;
   logic             reg_store_q, reg_store_d;
   logic             branch_taken_q, branch_taken_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] store_data_q, store_data_d;
   logic [WIDTH-1:0] dest_q, dest_d;

   logic [WIDTH-1:0] op_a, op_b, alu_res, acc_next;
   logic [3:0]       shamt;
   logic             stall_int;

   // Stall is decoded from state and opcode only, never from operand data.
   always_comb begin
      stall_int = 1'b0;
      if (!Reset) begin
         if (state_q == S_IDLE)
            stall_int = (IALUOP == OP_MUL);
         else
            stall_int = (count_q != LAST_COUNT);
      end
   end

   assign Stall = stall_int;

   always_comb begin
      op_a  = IRs1Val;
      op_b  = IALUSrc ? IImm : IRs2Val;
      shamt = op_b[3:0];
      case (IALUOP)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << shamt;
         OP_SRA:  alu_res = WIDTH'($signed(op_a) >>> shamt);
         default: alu_res = '0;
      endcase
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   always_comb begin
      state_d        = state_q;
      mcand_d        = mcand_q;
      mplier_d       = mplier_q;
      acc_d          = acc_q;
      count_d        = count_q;
      reg_write_d    = 1'b0;
      mem_write_d    = 1'b0;
      mem_read_d     = 1'b0;
      reg_store_d    = 1'b0;
      branch_taken_d = 1'b0;
      result_d       = '0;
      store_data_d   = '0;
      dest_d         = '0;

      case (state_q)
         S_IDLE: begin
            if (IALUOP == OP_MUL) begin
               state_d  = S_MUL;
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               count_d  = '0;
            end else begin
               reg_write_d    = IRegWrite;
               mem_write_d    = IMemWrite;
               mem_read_d     = IMemRead;
               reg_store_d    = IRegStore;
               branch_taken_d = IBranch && (op_a == op_b);
               result_d       = alu_res;
               store_data_d   = IRs2Val;
               dest_d         = IDest;
            end
         end
         S_MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (count_q == LAST_COUNT) begin
               // Operands are still held at ID/EX, so control and branch use them directly.
               state_d        = S_IDLE;
               reg_write_d    = IRegWrite;
               mem_write_d    = IMemWrite;
               mem_read_d     = IMemRead;
               reg_store_d    = IRegStore;
               branch_taken_d = IBranch && (op_a == op_b);
               result_d       = acc_next;
               store_data_d   = IRs2Val;
               dest_d         = IDest;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q        <= S_IDLE;
         mcand_q        <= '0;
         mplier_q       <= '0;
         acc_q          <= '0;
         count_q        <= '0;
         reg_write_q    <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_read_q     <= 1'b0;
         reg_store_q    <= 1'b0;
         branch_taken_q <= 1'b0;
         result_q       <= '0;
         store_data_q   <= '0;
         dest_q         <= '0;
      end else begin
         state_q        <= state_d;
         mcand_q        <= mcand_d;
         mplier_q       <= mplier_d;
         acc_q          <= acc_d;
         count_q        <= count_d;
         reg_write_q    <= reg_write_d;
         mem_write_q    <= mem_write_d;
         mem_read_q     <= mem_read_d;
         reg_store_q    <= reg_store_d;
         branch_taken_q <= branch_taken_d;
         result_q       <= result_d;
         store_data_q   <= store_data_d;
         dest_q         <= dest_d;
      end
   end

   assign ORegWrite    = reg_write_q;
   assign OMemWrite    = mem_write_q;
   assign OMemRead     = mem_read_q;
   assign ORegStore    = reg_store_q;
   assign OBranchTaken = branch_taken_q;
   assign OResult      = result_q;
   assign OStoreData   = store_data_q;
   assign ODest        = dest_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline. It consumes the decoded control and operand fields held in the ID/EX register and computes the ALU result and branch condition. It registers everything the memory stage needs into the EX/MEM boundary. It contains a 16-cycle iterative multiplier, and while a multiply is in progress it drives Stall to freeze the ID/EX register: ID/EX write-enable = ~Stall.

## Interface
Parameters:
- WIDTH, 16, datapath width; the multiplier iteration count equals WIDTH.

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  reset Reset, synchronous, active-high
- IRegWrite, IMemWrite, IMemRead, IRegStore, IBranch, IALUSrc  in  1 each  control from ID/EX
- IALUOP  in  3  operation select
- IRs1Val  in  WIDTH  operand A
- IRs2Val  in  WIDTH  operand B when IALUSrc=0; also the store data
- IImm  in  WIDTH  operand B when IALUSrc=1
- IDest  in  WIDTH  destination register field, passed through
- ORegWrite, OMemWrite, OMemRead, ORegStore  out  1 each  registered control to EX/MEM
- OBranchTaken  out  1  registered; IBranch && (A == B)
- OResult  out  WIDTH  registered ALU/multiply result
- OStoreData  out  WIDTH  registered IRs2Val
- ODest  out  WIDTH  registered IDest
- Stall  out  1  combinational; high means ID/EX holds

## Operation
- Operand selection: A = IRs1Val; B = IALUSrc ? IImm : IRs2Val.
- IALUOP encoding:
  - 000 add
  - 001 sub (A−B)
  - 010 and
  - 011 or
  - 100 xor
  - 101 shift left logical by B[3:0]
  - 110 shift right arithmetic by B[3:0]
  - 111 multiply, low WIDTH bits of A*B
- All arithmetic is mod 2^WIDTH; no flags and no overflow detection.
- The FSM has two states: IDLE and MUL.
  - IDLE, IALUOP≠111: single-cycle op. All outputs are loaded at the next edge. Stall=0.
  - IDLE, IALUOP=111: Stall=1. At the edge, load mcand←A, mplier←B, acc←0, count←0, and go to MUL. The EX/MEM outputs load a bubble at this edge: all control outputs and OBranchTaken = 0, data outputs = 0.
  - MUL: each edge performs:
    - if mplier[0], acc←acc+mcand
    - mcand←mcand<<1
    - mplier←mplier>>1
    - count←count+1
  - MUL with count≠WIDTH−1: Stall=1, and EX/MEM loads a bubble.
  - MUL with count=WIDTH−1: Stall=0. At the edge, OResult←acc+(mplier[0]?mcand:0). Control, ODest and OStoreData come from the held ID/EX inputs. The FSM returns to IDLE, and ID/EX advances on the same edge.
- During MUL, the ID/EX inputs are guaranteed stable because Stall holds them. The block latches its multiply operands at entry and does not re-read A or B in MUL.
- A multiply with IBranch=1 is legal. OBranchTaken is evaluated on the held A and B at completion.
- Back-to-back multiplies: the second one is seen in IDLE on the cycle after the first completes and starts normally.

## Timing
- Reset, on the edge it is sampled:
  - ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken = 0
  - OResult, OStoreData, ODest = 0
  - state = IDLE; acc, mcand, mplier, count = 0
  - Stall is combinational and is therefore forced to 0 while Reset=1.
- Reset mid-multiply aborts the multiply. No result is written, and the FSM is in IDLE the cycle after reset deasserts.
- Latency:
  - Non-multiply ops: 1 cycle from ID/EX output to EX/MEM output, with a throughput of 1 per cycle.
  - Multiply: occupies WIDTH+1 cycles with Stall high for WIDTH cycles. The result appears at EX/MEM WIDTH+1 edges after the op is presented, preceded by WIDTH bubbles.
- Stall depends only on state, count, IALUOP and Reset. It has no combinational path from the data inputs.

## Test plan
- Reset held for 2 cycles with the inputs nonzero → every output is 0 and Stall=0. IALUOP=000, A=0x0005, B=0x0003 after release → OResult=0x0008 one edge later.
- sub 0x0003−0x0005 → 0xFFFE. Then sra with A=0x8000, IImm=0x0004, IALUSrc=1 → 0xF800. Then sll with A=0x0001, B=0x0013 (shift amount 3) → 0x0008.
- Branch: IBranch=1, A=B=0x1234 → OBranchTaken=1. With A=0x1234, B=0x1235 → 0.
- Multiply A=0x0123, B=0x0010:
  - Stall is high for exactly 16 cycles.
  - 16 bubbles are emitted with all controls 0.
  - Then OResult=0x1230 with ORegWrite=1.
  - ID/EX advances only on the completion edge.
- Multiply 0xFFFF×0xFFFF → 0x0001. Then a back-to-back multiply 0x0100×0x0100 → 0x0000, started with no idle gap.
- Reset asserted at count=7 of a multiply → no result is produced and Stall=0. A following add 0x0002+0x0002 → 0x0004 with 1-cycle latency.
